// File: rtl/dcache_l2_port_if.sv
// Shared memory-op type and the bundled controller/L2 signal set for dcache_l2_port.
// The bridge uses the master view; the controller and L2 environment use the slave view.
package xentry_pkg;
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    STORE = 2'd1
  } mem_op_e;
endpackage

interface dcache_l2_port_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  import xentry_pkg::*;

  logic                  req_valid;
  mem_op_e               req_type;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  fetched_word_valid;
  logic [DATA_WIDTH-1:0] fetched_word;
  logic                  store_ack;
  logic                  l2_cmd_valid;
  logic                  l2_cmd_ready;
  mem_op_e               l2_cmd_type;
  logic [ADDR_WIDTH-1:0] l2_cmd_addr;
  logic [DATA_WIDTH-1:0] l2_cmd_wdata;
  logic                  l2_rsp_valid;
  logic [DATA_WIDTH-1:0] l2_rsp_rdata;
  logic                  l2_timeout_err;
  logic                  l2_protocol_err;

  modport master (
    input  req_valid, req_type, req_addr, req_wdata,
    input  l2_cmd_ready, l2_rsp_valid, l2_rsp_rdata,
    output fetched_word_valid, fetched_word, store_ack,
    output l2_cmd_valid, l2_cmd_type, l2_cmd_addr, l2_cmd_wdata,
    output l2_timeout_err, l2_protocol_err
  );

  modport slave (
    output req_valid, req_type, req_addr, req_wdata,
    output l2_cmd_ready, l2_rsp_valid, l2_rsp_rdata,
    input  fetched_word_valid, fetched_word, store_ack,
    input  l2_cmd_valid, l2_cmd_type, l2_cmd_addr, l2_cmd_wdata,
    input  l2_timeout_err, l2_protocol_err
  );
endinterface

// File: rtl/dcache_l2_port.sv
// Word-level bridge from the dcache controller's held LOAD/STORE request to a valid/ready L2
// command plus one-cycle response, one transaction in flight, with sticky error reporting.
module dcache_l2_port_chk
  import xentry_pkg::*;
(
  input logic    clk,
  input logic    reset_n,
  input logic    req_valid_i,
  input mem_op_e req_type_i,
  input logic    idle_i
);
  a_req_type_legal: assert property (@(posedge clk) disable iff (!reset_n)
    (idle_i && req_valid_i) |-> (req_type_i inside {LOAD, STORE}));
endmodule

module dcache_l2_port
  import xentry_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic              clk,
  input logic              reset_n,
  dcache_l2_port_if.master bus
);
  localparam int unsigned TW   = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMAX = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;
  localparam logic [TW-1:0] TMAX_L = TW'(TMAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e                state_q, state_d;
  mem_op_e               cmd_type_q, cmd_type_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_WIDTH-1:0] fetched_word_q, fetched_word_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  orphan_q, orphan_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  protocol_err_q, protocol_err_d;
  logic                  req_ok_s;
  logic                  orphan_eff_s;

  assign req_ok_s     = (bus.req_type == LOAD) || (bus.req_type == STORE);
  // A request dropped in the current cycle already counts as abandoned.
  assign orphan_eff_s = orphan_q | ~bus.req_valid;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cmd_type_q     <= LOAD;
      cmd_addr_q     <= {ADDR_WIDTH{1'b0}};
      cmd_wdata_q    <= {DATA_WIDTH{1'b0}};
      fetched_word_q <= {DATA_WIDTH{1'b0}};
      timer_q        <= {TW{1'b0}};
      orphan_q       <= 1'b0;
      timeout_err_q  <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_type_q     <= cmd_type_d;
      cmd_addr_q     <= cmd_addr_d;
      cmd_wdata_q    <= cmd_wdata_d;
      fetched_word_q <= fetched_word_d;
      timer_q        <= timer_d;
      orphan_q       <= orphan_d;
      timeout_err_q  <= timeout_err_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d        = state_q;
    cmd_type_d     = cmd_type_q;
    cmd_addr_d     = cmd_addr_q;
    cmd_wdata_d    = cmd_wdata_q;
    fetched_word_d = fetched_word_q;
    timer_d        = timer_q;
    orphan_d       = orphan_q;
    timeout_err_d  = timeout_err_q;

    // A response is only legal while waiting for one; late responses after a timeout land here too.
    if (bus.l2_rsp_valid && (state_q != ST_WAIT)) begin
      protocol_err_d = 1'b1;
    end else begin
      protocol_err_d = protocol_err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ok_s) begin
          state_d     = ST_CMD;
          cmd_type_d  = bus.req_type;
          cmd_addr_d  = bus.req_addr;
          cmd_wdata_d = bus.req_wdata;
          orphan_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        orphan_d = orphan_eff_s;
        if (bus.l2_cmd_ready) begin
          state_d = ST_WAIT;
          timer_d = {TW{1'b0}};
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_WAIT: begin
        orphan_d = orphan_eff_s;
        if (bus.l2_rsp_valid) begin
          state_d = ST_RESP;
          if ((cmd_type_q == LOAD) && !orphan_eff_s) begin
            fetched_word_d = bus.l2_rsp_rdata;
          end else begin
            fetched_word_d = fetched_word_q;
          end
        end else if ((TIMEOUT_CYCLES != 32'd0) && (timer_q == TMAX_L)) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.l2_cmd_valid       = (state_q == ST_CMD);
    bus.l2_cmd_type        = cmd_type_q;
    bus.l2_cmd_addr        = cmd_addr_q;
    bus.l2_cmd_wdata       = cmd_wdata_q;
    bus.fetched_word_valid = (state_q == ST_RESP) && (cmd_type_q == LOAD) && !orphan_q;
    bus.store_ack          = (state_q == ST_RESP) && (cmd_type_q == STORE) && !orphan_q;
    bus.fetched_word       = fetched_word_q;
    bus.l2_timeout_err     = timeout_err_q;
    bus.l2_protocol_err    = protocol_err_q;
  end

  dcache_l2_port_chk u_chk (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (bus.req_valid),
    .req_type_i  (bus.req_type),
    .idle_i      (state_q == ST_IDLE)
  );
endmodule

// File: tb/tb_dcache_l2_port.sv
// Directed bench for dcache_l2_port: a word-transaction table plus burst, timeout and reset sequences.
module tb_dcache_l2_port;
  import xentry_pkg::*;

  typedef struct {
    mem_op_e     typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] rdata;
    bit          drop;
    logic        exp_fv;
    logic        exp_sa;
    logic [31:0] exp_fw;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_pass;
  int   cf_cnt;
  int   fv_cnt;
  int   sa_cnt;
  logic [31:0] addr_log[$];
  vec_t vecs[7];

  dcache_l2_port_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dcache_l2_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: command handshakes and completion pulses.
  always @(posedge clk) begin
    if (bus.l2_cmd_valid && bus.l2_cmd_ready) begin
      cf_cnt <= cf_cnt + 1;
      addr_log.push_back(bus.l2_cmd_addr);
    end
    if (bus.fetched_word_valid) fv_cnt <= fv_cnt + 1;
    if (bus.store_ack) sa_cnt <= sa_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, 32'(bus.l2_cmd_valid), 32'd0);
    chk({tag, "_cmd_type"}, 32'(bus.l2_cmd_type), 32'(LOAD));
    chk({tag, "_cmd_addr"}, bus.l2_cmd_addr, 32'd0);
    chk({tag, "_cmd_wdata"}, bus.l2_cmd_wdata, 32'd0);
    chk({tag, "_fv"}, 32'(bus.fetched_word_valid), 32'd0);
    chk({tag, "_fw"}, bus.fetched_word, 32'd0);
    chk({tag, "_sa"}, 32'(bus.store_ack), 32'd0);
    chk({tag, "_tmo"}, 32'(bus.l2_timeout_err), 32'd0);
    chk({tag, "_prot"}, 32'(bus.l2_protocol_err), 32'd0);
  endtask

  // One word: request, optional ready stall, response after rsp_dly WAIT cycles.
  task automatic run_word(input vec_t v, input bit keep);
    int fv0, sa0, cf0;
    fv0 = fv_cnt; sa0 = sa_cnt; cf0 = cf_cnt;
    bus.req_valid = 1'b1;
    bus.req_type  = v.typ;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    tick();
    chk("cmd_valid", 32'(bus.l2_cmd_valid), 32'd1);
    chk("cmd_addr", bus.l2_cmd_addr, v.addr);
    chk("cmd_type", 32'(bus.l2_cmd_type), 32'(v.typ));
    chk("cmd_wdata", bus.l2_cmd_wdata, v.wdata);
    for (int i = 0; i < v.rdy_dly; i++) begin
      bus.l2_cmd_ready = 1'b0;
      tick();
      chk("stall_valid", 32'(bus.l2_cmd_valid), 32'd1);
      chk("stall_addr", bus.l2_cmd_addr, v.addr);
      chk("stall_wdata", bus.l2_cmd_wdata, v.wdata);
    end
    bus.l2_cmd_ready = 1'b1;
    tick();
    bus.l2_cmd_ready = 1'b0;
    chk("wait_valid", 32'(bus.l2_cmd_valid), 32'd0);
    if (v.drop) bus.req_valid = 1'b0;
    for (int i = 0; i < v.rsp_dly; i++) tick();
    bus.l2_rsp_valid = 1'b1;
    bus.l2_rsp_rdata = v.rdata;
    tick();
    bus.l2_rsp_valid = 1'b0;
    chk("fv_pulse", 32'(bus.fetched_word_valid), 32'(v.exp_fv));
    chk("sa_pulse", 32'(bus.store_ack), 32'(v.exp_sa));
    if (v.exp_fv) chk("fw_at_pulse", bus.fetched_word, v.exp_fw);
    if (!keep) bus.req_valid = 1'b0;
    tick();
    chk("fv_after", 32'(bus.fetched_word_valid), 32'd0);
    chk("sa_after", 32'(bus.store_ack), 32'd0);
    chk("fw_after", bus.fetched_word, v.exp_fw);
    chk("idle_after", 32'(bus.l2_cmd_valid), 32'd0);
    chk("fv_count", 32'(fv_cnt - fv0), 32'(v.exp_fv));
    chk("sa_count", 32'(sa_cnt - sa0), 32'(v.exp_sa));
    chk("cmd_count", 32'(cf_cnt - cf0), 32'd1);
  endtask

  initial begin
    vec_t bv;
    int rem;
    n_total = 0; n_pass = 0;
    cf_cnt = 0; fv_cnt = 0; sa_cnt = 0;

    //          typ    addr          wdata         rdy rsp rdata         drop fv    sa    fw
    vecs[0] = '{LOAD,  32'h0000_0040, 32'h0000_0000, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{STORE, 32'h0000_0080, 32'h1234_5678, 2, 4, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{LOAD,  32'h0000_0044, 32'h0000_0000, 1, 2, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 32'h0BAD_F00D};
    vecs[3] = '{LOAD,  32'h0000_0048, 32'h0000_0000, 0, 1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D};
    vecs[4] = '{STORE, 32'h0000_0100, 32'hCAFE_BABE, 1, 0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D};
    vecs[5] = '{LOAD,  32'hFFFF_FFFC, 32'h0000_0000, 0, 7, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h0000_0001};
    vecs[6] = '{STORE, 32'h0000_0000, 32'hFFFF_FFFF, 3, 0, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 32'h0000_0001};

    reset_n          = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_type     = LOAD;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.l2_cmd_ready = 1'b0;
    bus.l2_rsp_valid = 1'b0;
    bus.l2_rsp_rdata = 32'd0;
    repeat (2) tick();
    chk_all_zero("rst");
    reset_n = 1'b1;
    tick();
    chk("idle_post_rst", 32'(bus.l2_cmd_valid), 32'd0);

    for (int i = 0; i < 7; i++) run_word(vecs[i], 1'b0);
    chk("no_tmo_after_table", 32'(bus.l2_timeout_err), 32'd0);
    chk("no_prot_after_table", 32'(bus.l2_protocol_err), 32'd0);

    // 4-word LOAD burst with req_valid held; controller counts down on each pulse.
    addr_log.delete();
    rem = 4;
    for (int w = 0; w < 4; w++) begin
      int f0;
      f0 = fv_cnt;
      bv = '{LOAD, 32'h40 + 32'(4 * w), 32'h0, (w == 2) ? 3 : 0, 1,
             32'hC0DE_0000 + 32'(w), 1'b0, 1'b1, 1'b0, 32'hC0DE_0000 + 32'(w)};
      run_word(bv, w != 3);
      rem = rem - (fv_cnt - f0);
    end
    chk("burst_remaining", 32'(rem), 32'd0);
    chk("burst_cmds", 32'(addr_log.size()), 32'd4);
    for (int w = 0; w < 4 && w < addr_log.size(); w++)
      chk("burst_addr", addr_log[w], 32'h40 + 32'(4 * w));

    // Timeout: ready immediately, never respond.
    begin
      int f0, s0;
      f0 = fv_cnt; s0 = sa_cnt;
      bus.req_valid = 1'b1; bus.req_type = LOAD; bus.req_addr = 32'h200; bus.req_wdata = 32'd0;
      tick();
      bus.l2_cmd_ready = 1'b1;
      tick();
      bus.l2_cmd_ready = 1'b0;
      repeat (7) tick();
      chk("tmo_not_yet", 32'(bus.l2_timeout_err), 32'd0);
      bus.req_valid = 1'b0;
      tick();
      chk("tmo_set", 32'(bus.l2_timeout_err), 32'd1);
      chk("tmo_idle", 32'(bus.l2_cmd_valid), 32'd0);
      tick();
      chk("tmo_stay_idle", 32'(bus.l2_cmd_valid), 32'd0);
      chk("tmo_no_prot", 32'(bus.l2_protocol_err), 32'd0);
      bus.l2_rsp_valid = 1'b1; bus.l2_rsp_rdata = 32'h1111_2222;
      tick();
      bus.l2_rsp_valid = 1'b0;
      chk("late_rsp_prot", 32'(bus.l2_protocol_err), 32'd1);
      chk("late_rsp_no_fv", 32'(bus.fetched_word_valid), 32'd0);
      tick();
      chk("tmo_sticky", 32'(bus.l2_timeout_err), 32'd1);
      chk("prot_sticky", 32'(bus.l2_protocol_err), 32'd1);
      chk("tmo_fw_kept", bus.fetched_word, 32'hC0DE_0003);
      chk("tmo_no_pulses", 32'((fv_cnt - f0) + (sa_cnt - s0)), 32'd0);
    end

    // Asynchronous reset while a command is presented.
    bus.req_valid = 1'b1; bus.req_type = STORE; bus.req_addr = 32'h300; bus.req_wdata = 32'h7777_8888;
    tick();
    chk("pre_rst_cmd_valid", 32'(bus.l2_cmd_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    bus.req_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_release_idle", 32'(bus.l2_cmd_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
